// File: rtl/mem_bus_if.sv
// Request/completion and byte-wide memory bus between mem_bus_ctrl and its environment.
// The slave modport is the controller's view; master is the requester/memory side.
interface mem_bus_if;
  logic        readyIn;
  logic        clearIn;
  logic        reqValid;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic        busy;
  logic        doneValid;
  logic [31:0] doneData;
  logic [7:0]  memIn;
  logic [7:0]  memOut;
  logic [31:0] memAddr;
  logic        memWrite;
  logic        ioBufferFull;

  modport slave (
    input  readyIn, clearIn, reqValid, reqWrite, reqSize, reqAddr, reqData, memIn, ioBufferFull,
    output busy, doneValid, doneData, memOut, memAddr, memWrite
  );

  modport master (
    output readyIn, clearIn, reqValid, reqWrite, reqSize, reqAddr, reqData, memIn, ioBufferFull,
    input  busy, doneValid, doneData, memOut, memAddr, memWrite
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Serialises 1/2/4-byte load/store requests onto a byte-wide memory/IO bus,
// with UART back-pressure, an IO guard cycle, flush of reads and a global stall.
module mem_bus_ctrl (
  input  logic      clockIn,
  input  logic      resetIn,
  mem_bus_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, IO_WAIT, IO_GUARD} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_base, r_buf, r_doneData;
  logic [1:0]  r_last;
  logic [2:0]  r_cnt, w_cnt_nx;
  logic        r_done, w_done_nx;
  logic        w_accept, w_capture, w_is_io;
  logic [1:0]  w_last_req;
  logic [31:0] w_addr_cur, w_capt;
  logic [7:0]  w_byte;

  // Reads use r_cnt as the cycle index 0..N (issue k, capture k-1); writes use it as byte index.
  assign w_addr_cur = r_base + {29'b0, r_cnt};
  assign w_is_io    = (w_addr_cur[17:16] == 2'b11);

  always_comb begin
    case (bus.reqSize)
      2'd0:    w_last_req = 2'd0;
      2'd1:    w_last_req = 2'd1;
      default: w_last_req = 2'd3;
    endcase
  end

  always_comb begin
    w_capt = r_buf;
    case (r_cnt[1:0])
      2'd1: w_capt[7:0]   = bus.memIn;
      2'd2: w_capt[15:8]  = bus.memIn;
      2'd3: w_capt[23:16] = bus.memIn;
      2'd0: w_capt[31:24] = bus.memIn;
    endcase
  end

  always_comb begin
    case (r_cnt[1:0])
      2'd0: w_byte = r_buf[7:0];
      2'd1: w_byte = r_buf[15:8];
      2'd2: w_byte = r_buf[23:16];
      2'd3: w_byte = r_buf[31:24];
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_done_nx  = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.reqValid && !bus.clearIn) begin
          w_accept = 1'b1;
          w_cnt_nx = 3'd0;
          if (!bus.reqWrite)
            w_state_nx = READ;
          else if (bus.reqAddr[17:16] == 2'b11 && bus.ioBufferFull)
            w_state_nx = IO_WAIT;
          else
            w_state_nx = WRITE;
        end
      end
      READ: begin
        if (bus.clearIn) begin
          w_state_nx = IDLE;
        end else begin
          w_capture = (r_cnt != 3'd0);
          if (r_cnt == {1'b0, r_last} + 3'd1) begin
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + 3'd1;
          end
        end
      end
      WRITE: begin
        if (w_is_io) begin
          w_state_nx = IO_GUARD;
        end else if (r_cnt[1:0] == r_last) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 3'd1;
        end
      end
      IO_WAIT: begin
        if (!bus.ioBufferFull) w_state_nx = WRITE;
      end
      IO_GUARD: begin
        if (r_cnt[1:0] == r_last) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
        end else begin
          w_state_nx = WRITE;
          w_cnt_nx   = r_cnt + 3'd1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // readyIn low holds every register, including a pending done pulse.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_done     <= 1'b0;
      r_base     <= 32'h0;
      r_buf      <= 32'h0;
      r_last     <= 2'd0;
      r_doneData <= 32'h0;
    end else if (bus.readyIn) begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_done_nx;
      if (w_accept) begin
        r_base <= bus.reqAddr;
        r_last <= w_last_req;
        r_buf  <= bus.reqWrite ? bus.reqData : 32'h0;
      end
      if (w_capture) r_buf <= w_capt;
      if (w_done_nx) r_doneData <= (r_state == READ) ? w_capt : 32'h0;
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.doneValid = r_done;
  assign bus.doneData  = r_doneData;
  assign bus.memWrite  = (r_state == WRITE) && bus.readyIn;
  assign bus.memOut    = (r_state == WRITE) ? w_byte : 8'h0;

  // While stalled mid-read, re-present the byte still awaiting capture.
  always_comb begin
    if (r_state == IDLE)
      bus.memAddr = 32'h0;
    else if (r_state == READ && !bus.readyIn && r_cnt != 3'd0)
      bus.memAddr = w_addr_cur - 32'd1;
    else
      bus.memAddr = w_addr_cur;
  end
endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clockIn  in  1  system clock, rising edge.
REQ-002 resetIn  in  1  synchronous active-high reset.
REQ-003 readyIn  in  1  global ready; low = pause.
REQ-004 clearIn  in  1  misprediction flush.
REQ-005 reqValid  in  1  request strobe, sampled only in IDLE.
REQ-006 reqWrite  in  1  1 = write, 0 = read.
REQ-007 reqSize  in  2  byte count N-1 (0 = 1 B, 1 = 2 B, 3 = 4 B; value 2 is treated as 3).
REQ-008 reqAddr  in  32  byte address of the first byte.
REQ-009 reqData  in  32  write data, little-endian; byte k = reqData[8k+7:8k].
REQ-010 busy  out  1  high when state != IDLE.
REQ-011 doneValid  out  1  one-cycle completion pulse.
REQ-012 doneData  out  32  read data, zero-extended; 0 after writes.
REQ-013 memIn  in  8  memory/IO read byte; valid one cycle after its address.
REQ-014 memOut  out  8  write byte.
REQ-015 memAddr  out  32  byte address.
REQ-016 memWrite  out  1  1 = write this cycle.
REQ-017 ioBufferFull  in  1  UART TX buffer full.

Function
REQ-018 States SHALL be: IDLE, READ, WRITE, IO_WAIT, IO_GUARD.
REQ-019 In IDLE with reqValid=1, the block SHALL latch the request at the edge; the next state is READ, WRITE, or IO_WAIT (write with reqAddr[17:16]=2'b11 and ioBufferFull=1).
REQ-020 A read of N bytes accepted at edge t SHALL drive memAddr=reqAddr+k in cycle t+1+k (k=0..N-1), capture memIn at the end of cycle t+2+k into byte k, and assert doneValid with complete doneData in cycle t+N+2.
REQ-021 A write of N bytes accepted at edge t SHALL drive memWrite=1, memAddr=reqAddr+k, and memOut=byte k in cycle t+1+k, and assert doneValid in cycle t+N+1.
REQ-022 Address increments SHALL be 32-bit modulo 2^32; wrap is not an error.
REQ-023 IO_WAIT SHALL hold memWrite=0 while ioBufferFull=1, then issue the write as in REQ-021.
REQ-024 After any write byte to an address with [17:16]=2'b11, the block SHALL spend one IO_GUARD cycle (memWrite=0) before the next byte or doneValid.
REQ-025 doneValid cycles SHALL be spent in IDLE, so a new request MAY be accepted in the same cycle as doneValid (back-to-back).
REQ-026 reqValid while busy=1 SHALL be ignored; the requester holds it.
REQ-027 clearIn=1 in READ SHALL return the block to IDLE at that edge with no doneValid.
REQ-028 clearIn SHALL be ignored in WRITE, IO_WAIT, and IO_GUARD; committed writes always complete.
REQ-029 clearIn=1 with reqValid=1 in IDLE SHALL drop the request.
REQ-030 readyIn=0 SHALL freeze all state, force memWrite=0, and drive memAddr with the address of the oldest uncaptured read byte, so that capture resumes correctly on the first ready cycle.
REQ-031 In IDLE, memAddr, memOut, and memWrite SHALL be 0.

Reset
REQ-032 resetIn=1 SHALL force IDLE, busy=0, doneValid=0, doneData=0, memAddr=0, memOut=0, and memWrite=0 at the next edge, aborting any transfer, including a mid-write.
REQ-033 resetIn SHALL take priority over readyIn and clearIn.

Verification
REQ-034 Word read of 0x00001000, memory bytes 11,22,33,44, accepted at t -> memAddr 0x1000..0x1003 in t+1..t+4; doneValid in t+6 with doneData=0x44332211.
REQ-035 Halfword write of 0xBEEF to 0x00000FFF -> memWrite=1 with (0xFFF,0xEF) in t+1 and (0x1000,0xBE) in t+2; doneValid in t+3.
REQ-036 Byte write 0x41 to 0x00030000 with ioBufferFull=1 for 3 cycles -> no memWrite for 3 cycles, then one write, one IO_GUARD cycle, then doneValid.
REQ-037 Word read with readyIn=0 for 2 cycles after byte 1 is issued -> no memWrite, memAddr = byte-1 address during the stall; final doneData matches the stall-free result; done is delayed exactly 2 cycles.
REQ-038 clearIn during a read at k=2 -> IDLE next cycle, no doneValid; a new request is accepted the following cycle; clearIn during a write -> the write completes unchanged.
REQ-039 resetIn during a word write after byte 1 -> all outputs 0 next cycle and busy=0.
